// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and shared memory port of mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory-model side.
interface mem_arbiter_if;
    logic        i_req_valid;
    logic [31:0] i_rd_addr;
    logic [31:0] i_rd_data;
    logic        i_ack;
    logic        i_err;

    logic        d_req_valid;
    logic        d_rd_wr;
    logic [31:0] d_rd_addr;
    logic [31:0] d_wr_addr;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;
    logic        d_ack;
    logic        d_err;

    logic        mem_req_valid;
    logic        mem_rd_wr;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_ack;

    modport slave (
        input  i_req_valid, i_rd_addr,
        input  d_req_valid, d_rd_wr, d_rd_addr, d_wr_addr, d_wr_data,
        input  mem_rd_data, mem_ack,
        output i_rd_data, i_ack, i_err,
        output d_rd_data, d_ack, d_err,
        output mem_req_valid, mem_rd_wr, mem_rd_addr, mem_wr_addr, mem_wr_data
    );

    modport master (
        output i_req_valid, i_rd_addr,
        output d_req_valid, d_rd_wr, d_rd_addr, d_wr_addr, d_wr_data,
        output mem_rd_data, mem_ack,
        input  i_rd_data, i_ack, i_err,
        input  d_rd_data, d_ack, d_err,
        input  mem_req_valid, mem_rd_wr, mem_rd_addr, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data accesses.
// Define MEM_ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT_CYCLES cycles without mem_ack.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    logic   last_grant_data;
    logic   grant_data;
    logic   pick_fetch;

    // Fetch wins when alone, or on a tie when data held the previous grant.
    assign pick_fetch = bus.i_req_valid && (!bus.d_req_valid || last_grant_data);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] busy_cnt;
    logic             busy_expired;
    assign busy_expired = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign bus.i_err = 1'b0;
    assign bus.d_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            last_grant_data   <= 1'b1;
            grant_data        <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_rd_wr     <= 1'b0;
            bus.mem_rd_addr   <= 32'h0;
            bus.mem_wr_addr   <= 32'h0;
            bus.mem_wr_data   <= 32'h0;
            bus.i_ack         <= 1'b0;
            bus.i_rd_data     <= 32'h0;
            bus.d_ack         <= 1'b0;
            bus.d_rd_data     <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt          <= '0;
            bus.i_err         <= 1'b0;
            bus.d_err         <= 1'b0;
`endif
        end else begin
            // Completion strobes and return data are single-cycle; clear them by default.
            bus.i_ack     <= 1'b0;
            bus.i_rd_data <= 32'h0;
            bus.d_ack     <= 1'b0;
            bus.d_rd_data <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus.i_err     <= 1'b0;
            bus.d_err     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.i_req_valid || bus.d_req_valid) begin
                        state             <= BUSY;
                        bus.mem_req_valid <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        busy_cnt          <= '0;
`endif
                        if (pick_fetch) begin
                            grant_data      <= 1'b0;
                            last_grant_data <= 1'b0;
                            bus.mem_rd_wr   <= 1'b0;
                            bus.mem_rd_addr <= bus.i_rd_addr;
                            bus.mem_wr_addr <= 32'h0;
                            bus.mem_wr_data <= 32'h0;
                        end else begin
                            grant_data      <= 1'b1;
                            last_grant_data <= 1'b1;
                            bus.mem_rd_wr   <= bus.d_rd_wr;
                            bus.mem_rd_addr <= bus.d_rd_addr;
                            bus.mem_wr_addr <= bus.d_wr_addr;
                            bus.mem_wr_data <= bus.d_wr_data;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        state             <= DONE;
                        bus.mem_req_valid <= 1'b0;
                        if (grant_data) begin
                            bus.d_ack     <= 1'b1;
                            bus.d_rd_data <= bus.mem_rd_wr ? 32'h0 : bus.mem_rd_data;
                        end else begin
                            bus.i_ack     <= 1'b1;
                            bus.i_rd_data <= bus.mem_rd_data;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (busy_expired) begin
                        state             <= DONE;
                        bus.mem_req_valid <= 1'b0;
                        if (grant_data) begin
                            bus.d_ack <= 1'b1;
                            bus.d_err <= 1'b1;
                        end else begin
                            bus.i_ack <= 1'b1;
                            bus.i_err <= 1'b1;
                        end
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end
                // One dead cycle lets the served requester drop valid before the next grant.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, number of BUSY cycles without mem_ack before abort; used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 i_req_valid  in  1  instruction-fetch read request; held until i_ack.
REQ-005 i_rd_addr  in  32  fetch address.
REQ-006 i_rd_data  out  32  fetch data; valid while i_ack=1.
REQ-007 i_ack  out  1  one-cycle completion pulse, fetch port.
REQ-008 i_err  out  1  one-cycle timeout pulse, fetch port; coincides with i_ack.
REQ-009 d_req_valid  in  1  data request; held until d_ack.
REQ-010 d_rd_wr  in  1  0 = read, 1 = write.
REQ-011 d_rd_addr / d_wr_addr / d_wr_data  in  32 each  data-port read address, write address, write data.
REQ-012 d_rd_data  out  32  read data; valid while d_ack=1.
REQ-013 d_ack / d_err  out  1 each  one-cycle completion / timeout pulses, data port.
REQ-014 mem_req_valid  out  1  request to memory; held until mem_ack.
REQ-015 mem_rd_wr  out  1  0 = read, 1 = write.
REQ-016 mem_rd_addr / mem_wr_addr / mem_wr_data  out  32 each  registered copy of granted request.
REQ-017 mem_rd_data  in  32  memory read data; sampled when mem_ack=1.
REQ-018 mem_ack  in  1  memory completion.

Function
REQ-019 FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 IDLE: if any req_valid, SHALL grant, register the request onto mem_* outputs, assert mem_req_valid, and enter BUSY next cycle.
REQ-021 Arbitration SHALL be round-robin: both valid -> grant the port not granted last; one valid -> grant it.
REQ-022 Fetch grants SHALL drive mem_rd_wr=0, mem_wr_addr=0, mem_wr_data=0.
REQ-023 mem_* outputs SHALL remain stable throughout BUSY.
REQ-024 BUSY with mem_ack=1: next cycle SHALL be DONE, with mem_req_valid=0, the granted port's ack=1, and its rd_data=mem_rd_data (reads) or 0 (writes).
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE without granting, so requesters can drop valid.
REQ-026 Latency: request seen at edge N -> mem_req_valid high in cycle N+1; mem_ack sampled at edge M -> port ack high in cycle M+1; next grant no earlier than cycle M+3.
REQ-027 mem_ack in IDLE or DONE SHALL be ignored.
REQ-028 Non-granted port ack/err/rd_data SHALL stay 0; rd_data SHALL be 0 whenever its ack=0.
REQ-029 A request arriving during BUSY/DONE SHALL wait; it is never lost.

Reset
REQ-030 reset=1 SHALL force next-cycle state IDLE, all outputs 0, last-grant = data port (fetch wins the first tie).
REQ-031 Reset mid-transaction SHALL abandon it: no ack/err issued, mem_req_valid drops next cycle.

Configuration
REQ-032 Macro MEM_ARB_TIMEOUT_EN defined: BUSY cycle counter; on TIMEOUT_CYCLES consecutive BUSY cycles without mem_ack, next cycle SHALL be DONE with mem_req_valid=0 and granted port ack=1, err=1, rd_data=0; counter clears on BUSY entry.
REQ-033 Macro not defined: no counter; BUSY waits indefinitely; i_err and d_err tied 0.

Verification
REQ-034 Fetch only: i_rd_addr=0x100, memory acks after 2 cycles with 0xDEADBEEF -> mem_rd_addr=0x100, mem_rd_wr=0, i_ack one cycle with i_rd_data=0xDEADBEEF.
REQ-035 Data write: d_rd_wr=1, d_wr_addr=0x2000, d_wr_data=0x12345678 -> mem_rd_wr=1, mem_wr_addr/data match, d_ack pulse with d_rd_data=0.
REQ-036 Both valid from reset, held for 4 transactions -> grant order I, D, I, D; no overlap on mem_req_valid.
REQ-037 Reset asserted in BUSY of fetch 0x40 -> mem_req_valid=0 next cycle, no i_ack, next tie grants fetch.
REQ-038 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mem_ack -> d_ack=d_err=1 in cycle 9 after grant, d_rd_data=0; late mem_ack ignored.
REQ-039 mem_ack pulsed in IDLE with no request -> no ack, state stays IDLE.
